// File: rtl/seg_disp_pkg.sv
// Shared seven-segment display types, used by the scan driver and the
// pattern generator.
//   N_DIG      digits per bank
//   seg_t      one digit's segments {dp,g,f,e,d,c,b,a}, active-low
//   SEG_BLANK  all segments off
//   seg_bank_t one bank of N_DIG digits; byte k is digit k
//   dig_sel()  active-low one-hot digit select for a digit index
package seg_disp_pkg;

  localparam int unsigned N_DIG = 8;
  localparam int unsigned IDX_W = $clog2(N_DIG);

  typedef logic [7:0] seg_t;
  typedef seg_t [N_DIG-1:0] seg_bank_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  function automatic seg_t dig_sel(input logic [IDX_W-1:0] i);
    return ~(seg_t'(1) << i);
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer for the digit scan.
//   clk, sys_rstn  clock, async active-low reset
//   en             scan enable; low holds the counters at zero
//   idx            digit index currently being scanned
//   in_blank       current cycle is in the anti-ghosting gap (or not running)
//   frame_start    the next cycle is a frame start (cnt=0, idx=0)
// The first enabled edge only arms the timer without advancing it, so the
// cycle after that edge already sits at cnt=0, idx=0 as a frame start.
module seg_scan_timer
  import seg_disp_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 200_000,
  parameter int unsigned BLANK_CYCLES = 2_000
) (
  input  logic             clk,
  input  logic             sys_rstn,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             in_blank,
  output logic             frame_start
);

  localparam int unsigned CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;
  logic             run;
  logic             slot_end;
  logic             cnt_in_gap;

  assign slot_end = (cnt == CNT_W'(DIGIT_CYCLES - 1));

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt <= '0;
      idx <= '0;
      run <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      idx <= '0;
      run <= 1'b0;
    end else if (!run) begin
      run <= 1'b1;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A zero-length gap would otherwise need an always-false unsigned compare.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_gap
      assign cnt_in_gap = 1'b0;
    end else begin : g_gap
      assign cnt_in_gap = (cnt < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  assign in_blank    = !run || cnt_in_gap;
  assign frame_start = en && (!run || (slot_end && (idx == IDX_W'(N_DIG - 1))));

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan driver for two 8-digit seven-segment banks.
// Holds a shadow and an active pattern per bank; shadow updates move to the
// active buffer only at a frame start so a rotation never tears across digits.
//   clk, sys_rstn   clock, async active-low reset
//   en              scan enable
//   upd             one-cycle strobe capturing pat1/pat2
//   pat1, pat2      bank patterns, byte k = digit k, active-low segments
//   upd_busy        shadow holds data not yet transferred
//   frame           one-cycle pulse in each frame-start cycle
//   seg_sel         active-low digit select
//   seg_led1/2      bank segments for the selected digit
module seg_scan_mux
  import seg_disp_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 200_000,
  parameter int unsigned BLANK_CYCLES = 2_000
) (
  input  logic        clk,
  input  logic        sys_rstn,
  input  logic        en,
  input  logic        upd,
  input  logic [63:0] pat1,
  input  logic [63:0] pat2,
  output logic        upd_busy,
  output logic        frame,
  output logic [7:0]  seg_sel,
  output logic [7:0]  seg_led1,
  output logic [7:0]  seg_led2
);

  seg_bank_t        act1, act2;
  seg_bank_t        shd1, shd2;
  logic [IDX_W-1:0] idx;
  logic             in_blank;
  logic             frame_start;

  seg_scan_timer #(
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .sys_rstn   (sys_rstn),
    .en         (en),
    .idx        (idx),
    .in_blank   (in_blank),
    .frame_start(frame_start)
  );

  // A strobe landing on the frame-start edge goes to the shadow while the
  // old shadow moves to active, so busy stays set for the following frame.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      act1     <= {N_DIG{SEG_BLANK}};
      act2     <= {N_DIG{SEG_BLANK}};
      shd1     <= {N_DIG{SEG_BLANK}};
      shd2     <= {N_DIG{SEG_BLANK}};
      upd_busy <= 1'b0;
    end else if (en) begin
      if (frame_start && upd_busy) begin
        act1 <= shd1;
        act2 <= shd2;
      end
      if (upd) begin
        shd1     <= pat1;
        shd2     <= pat2;
        upd_busy <= 1'b1;
      end else if (frame_start) begin
        upd_busy <= 1'b0;
      end
    end else if (upd) begin
      act1     <= pat1;
      act2     <= pat2;
      shd1     <= pat1;
      shd2     <= pat2;
      upd_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      frame    <= 1'b0;
      seg_sel  <= SEG_BLANK;
      seg_led1 <= SEG_BLANK;
      seg_led2 <= SEG_BLANK;
    end else begin
      frame <= frame_start;
      if (in_blank) begin
        seg_sel  <= SEG_BLANK;
        seg_led1 <= SEG_BLANK;
        seg_led2 <= SEG_BLANK;
      end else begin
        seg_sel  <= dig_sel(idx);
        seg_led1 <= act1[idx];
        seg_led2 <= act2[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;
  import seg_disp_pkg::*;

  logic        clk = 1'b0;
  logic        sys_rstn;
  logic        en;
  logic        upd;
  logic [63:0] pat1, pat2;
  logic        upd_busy, frame;
  logic [7:0]  seg_sel, seg_led1, seg_led2;
  logic        upd_busy0, frame0;
  logic [7:0]  seg_sel0, seg_led10, seg_led20;

  int checks = 0;
  int failures = 0;
  int ecount = -1;

  always #5 clk = ~clk;

  seg_scan_mux #(.DIGIT_CYCLES(10), .BLANK_CYCLES(2)) dut (
    .clk(clk), .sys_rstn(sys_rstn), .en(en), .upd(upd), .pat1(pat1), .pat2(pat2),
    .upd_busy(upd_busy), .frame(frame), .seg_sel(seg_sel),
    .seg_led1(seg_led1), .seg_led2(seg_led2)
  );

  seg_scan_mux #(.DIGIT_CYCLES(10), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .sys_rstn(sys_rstn), .en(en), .upd(upd), .pat1(pat1), .pat2(pat2),
    .upd_busy(upd_busy0), .frame(frame0), .seg_sel(seg_sel0),
    .seg_led1(seg_led10), .seg_led2(seg_led20)
  );

  typedef struct {
    int         e;
    logic       do_upd;
    logic [7:0] pb;
    logic [7:0] sel;
    logic [7:0] led1;
    logic [7:0] led2;
    logic       frm;
    logic       busy;
    logic [7:0] sel0;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int e, logic u, logic [7:0] pb, logic [7:0] sel,
                              logic [7:0] l1, logic [7:0] l2, logic frm,
                              logic busy, logic [7:0] sel0);
    vec_t v;
    v.e = e; v.do_upd = u; v.pb = pb; v.sel = sel; v.led1 = l1; v.led2 = l2;
    v.frm = frm; v.busy = busy; v.sel0 = sel0;
    return v;
  endfunction

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic chk(input string name, input int e, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h want=%h", name, e, act, exp);
    end
  endtask

  // Advance to the given edge (counted from the first enabled edge) and
  // return 1 time unit after it; upd is a one-cycle strobe.
  task automatic to_edge(input int e);
    while (ecount < e) begin
      @(posedge clk);
      #1;
      ecount++;
      upd = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d got=running want=finished", ecount);
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rstn = 1'b0;
    en       = 1'b0;
    upd      = 1'b0;
    pat1     = 64'h0706050403020100;
    pat2     = 64'h1716151413121110;

    // edge, upd, byte, sel, led1, led2, frame, busy, sel (B=0)
    tbl.push_back(mk(  0, 0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1, 0, 8'hFF));
    tbl.push_back(mk(  1, 0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 0, 0, 8'hFE));
    tbl.push_back(mk(  2, 0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 0, 0, 8'hFE));
    tbl.push_back(mk(  3, 0, 8'h00, 8'hFE, 8'h00, 8'h10, 0, 0, 8'hFE));
    tbl.push_back(mk( 10, 0, 8'h00, 8'hFE, 8'h00, 8'h10, 0, 0, 8'hFE));
    tbl.push_back(mk( 11, 0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 0, 0, 8'hFD));
    tbl.push_back(mk( 12, 0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 0, 0, 8'hFD));
    tbl.push_back(mk( 13, 0, 8'h00, 8'hFD, 8'h01, 8'h11, 0, 0, 8'hFD));
    tbl.push_back(mk( 25, 1, 8'hC0, 8'hFB, 8'h02, 8'h12, 0, 0, 8'hFB));
    tbl.push_back(mk( 26, 0, 8'h00, 8'hFB, 8'h02, 8'h12, 0, 1, 8'hFB));
    tbl.push_back(mk( 33, 0, 8'h00, 8'hF7, 8'h03, 8'h13, 0, 1, 8'hF7));
    tbl.push_back(mk( 79, 0, 8'h00, 8'h7F, 8'h07, 8'h17, 0, 1, 8'h7F));
    tbl.push_back(mk( 80, 0, 8'h00, 8'h7F, 8'h07, 8'h17, 1, 0, 8'h7F));
    tbl.push_back(mk( 81, 0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 0, 0, 8'hFE));
    tbl.push_back(mk( 83, 0, 8'h00, 8'hFE, 8'hC0, 8'h10, 0, 0, 8'hFE));
    tbl.push_back(mk( 85, 1, 8'hA1, 8'hFE, 8'hC0, 8'h10, 0, 0, 8'hFE));
    tbl.push_back(mk( 95, 1, 8'hB2, 8'hFD, 8'hC0, 8'h11, 0, 1, 8'hFD));
    tbl.push_back(mk(105, 1, 8'hC3, 8'hFB, 8'hC0, 8'h12, 0, 1, 8'hFB));
    tbl.push_back(mk(113, 0, 8'h00, 8'hF7, 8'hC0, 8'h13, 0, 1, 8'hF7));
    tbl.push_back(mk(160, 0, 8'h00, 8'h7F, 8'hC0, 8'h17, 1, 0, 8'h7F));
    tbl.push_back(mk(163, 0, 8'h00, 8'hFE, 8'hC3, 8'h10, 0, 0, 8'hFE));
    tbl.push_back(mk(234, 1, 8'hE5, 8'h7F, 8'hC3, 8'h17, 0, 0, 8'h7F));
    tbl.push_back(mk(235, 0, 8'h00, 8'h7F, 8'hC3, 8'h17, 0, 1, 8'h7F));
    tbl.push_back(mk(239, 1, 8'hD4, 8'h7F, 8'hC3, 8'h17, 0, 1, 8'h7F));
    tbl.push_back(mk(240, 0, 8'h00, 8'h7F, 8'hC3, 8'h17, 1, 1, 8'h7F));
    tbl.push_back(mk(243, 0, 8'h00, 8'hFE, 8'hE5, 8'h10, 0, 1, 8'hFE));
    tbl.push_back(mk(320, 0, 8'h00, 8'h7F, 8'hE5, 8'h17, 1, 0, 8'h7F));
    tbl.push_back(mk(323, 0, 8'h00, 8'hFE, 8'hD4, 8'h10, 0, 0, 8'hFE));

    // reset state
    #12;
    chk("rst_sel",   0, seg_sel, 8'hFF);
    chk("rst_led1",  0, seg_led1, 8'hFF);
    chk("rst_led2",  0, seg_led2, 8'hFF);
    chk("rst_busy",  0, {7'b0, upd_busy}, 8'h00);
    chk("rst_frame", 0, {7'b0, frame}, 8'h00);

    // load the initial pattern with scanning stopped (direct write)
    @(negedge clk) sys_rstn = 1'b1;
    @(negedge clk) upd = 1'b1;
    @(negedge clk) upd = 1'b0;
    chk("idle_busy", 0, {7'b0, upd_busy}, 8'h00);
    @(negedge clk) en = 1'b1;
    ecount = -1;

    for (int i = 0; i < tbl.size(); i++) begin
      to_edge(tbl[i].e);
      chk("sel",   tbl[i].e, seg_sel, tbl[i].sel);
      chk("led1",  tbl[i].e, seg_led1, tbl[i].led1);
      chk("led2",  tbl[i].e, seg_led2, tbl[i].led2);
      chk("frame", tbl[i].e, {7'b0, frame}, {7'b0, tbl[i].frm});
      chk("busy",  tbl[i].e, {7'b0, upd_busy}, {7'b0, tbl[i].busy});
      chk("sel_b0", tbl[i].e, seg_sel0, tbl[i].sel0);
      if (tbl[i].do_upd) begin
        upd  = 1'b1;
        pat1 = rep(tbl[i].pb);
      end
    end

    // enable dropped mid-DRIVE of digit 4 (edge 47 of the frame at 320)
    to_edge(366);
    en = 1'b0;
    to_edge(367);
    chk("endrop_sel", 367, seg_sel, 8'hEF);
    chk("endrop_led1", 367, seg_led1, 8'hD4);
    to_edge(368);
    chk("off_sel",  368, seg_sel, 8'hFF);
    chk("off_led1", 368, seg_led1, 8'hFF);
    chk("off_led2", 368, seg_led2, 8'hFF);
    chk("off_sel_b0", 368, seg_sel0, 8'hFF);
    to_edge(372);
    chk("off_frame", 372, {7'b0, frame}, 8'h00);
    upd  = 1'b1;
    pat1 = rep(8'h5A);
    to_edge(373);
    chk("direct_busy", 373, {7'b0, upd_busy}, 8'h00);
    to_edge(374);
    en = 1'b1;
    to_edge(375);
    chk("reen_frame", 375, {7'b0, frame}, 8'h01);
    to_edge(376);
    chk("reen_frame_off", 376, {7'b0, frame}, 8'h00);
    to_edge(378);
    chk("reen_sel",  378, seg_sel, 8'hFE);
    chk("reen_led1", 378, seg_led1, 8'h5A);
    chk("reen_led2", 378, seg_led2, 8'h10);

    // asynchronous reset pulse in the middle of a DRIVE cycle
    #2;
    sys_rstn = 1'b0;
    #1;
    chk("arst_sel",  378, seg_sel, 8'hFF);
    chk("arst_led1", 378, seg_led1, 8'hFF);
    chk("arst_led2", 378, seg_led2, 8'hFF);
    chk("arst_sel_b0", 378, seg_sel0, 8'hFF);
    chk("arst_busy", 378, {7'b0, upd_busy}, 8'h00);
    @(negedge clk) sys_rstn = 1'b1;
    ecount = -1;
    to_edge(0);
    chk("post_frame", 0, {7'b0, frame}, 8'h01);
    to_edge(1);
    chk("post_sel_b0",  1, seg_sel0, 8'hFE);
    chk("post_led1_b0", 1, seg_led10, 8'hFF);
    to_edge(3);
    chk("post_sel",  3, seg_sel, 8'hFE);
    chk("post_led1", 3, seg_led1, 8'hFF);
    chk("post_led2", 3, seg_led2, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
